// File: rtl/sha256_round_engine.sv
// sha256_round_engine
//   Runs the 64 SHA-256 compression rounds for one block, one round per clock,
//   using a fully expanded message schedule, then adds the working variables
//   back into the chaining value.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   start              compress one block (honoured only while idle)
//   abort              synchronous return to idle; suppresses hash_valid
//   w_vector_complete  schedule words are ready (honoured only in WAIT_W)
//   w_vector           64 schedule words, word t at [32t+31:32t]
//   hash_in            chaining value H0..H7, H0 at [255:224]
//   busy               high while waiting for W, running rounds or finalising
//   hash_valid         one-cycle pulse when hash_out updates
//   hash_out           new chaining value, same word order as hash_in
//   round_index        current round t (63 while finalising, 0 otherwise)
module sha256_round_engine #(
  parameter int unsigned W_LENGTH = 64  // only 64 is supported
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    w_vector_complete,
  input  logic [W_LENGTH*32-1:0]  w_vector,
  input  logic [255:0]            hash_in,
  output logic                    busy,
  output logic                    hash_valid,
  output logic [255:0]            hash_out,
  output logic [6:0]              round_index
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_W = 2'd1;
  localparam logic [1:0] ST_ROUND  = 2'd2;
  localparam logic [1:0] ST_FINAL  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [255:0] hv_q, hv_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic         hash_valid_q, hash_valid_d;

  logic [31:0]  k_t;
  logic [31:0]  w_t;
  logic [31:0]  sum0, sum1, ch, maj, t1, t2;

  // Round constant ROM, indexed by the round counter.
  always_comb begin
    k_t = '0;
    case (t_q)
      6'd0:  k_t = 32'h428a2f98;  6'd1:  k_t = 32'h71374491;
      6'd2:  k_t = 32'hb5c0fbcf;  6'd3:  k_t = 32'he9b5dba5;
      6'd4:  k_t = 32'h3956c25b;  6'd5:  k_t = 32'h59f111f1;
      6'd6:  k_t = 32'h923f82a4;  6'd7:  k_t = 32'hab1c5ed5;
      6'd8:  k_t = 32'hd807aa98;  6'd9:  k_t = 32'h12835b01;
      6'd10: k_t = 32'h243185be;  6'd11: k_t = 32'h550c7dc3;
      6'd12: k_t = 32'h72be5d74;  6'd13: k_t = 32'h80deb1fe;
      6'd14: k_t = 32'h9bdc06a7;  6'd15: k_t = 32'hc19bf174;
      6'd16: k_t = 32'he49b69c1;  6'd17: k_t = 32'hefbe4786;
      6'd18: k_t = 32'h0fc19dc6;  6'd19: k_t = 32'h240ca1cc;
      6'd20: k_t = 32'h2de92c6f;  6'd21: k_t = 32'h4a7484aa;
      6'd22: k_t = 32'h5cb0a9dc;  6'd23: k_t = 32'h76f988da;
      6'd24: k_t = 32'h983e5152;  6'd25: k_t = 32'ha831c66d;
      6'd26: k_t = 32'hb00327c8;  6'd27: k_t = 32'hbf597fc7;
      6'd28: k_t = 32'hc6e00bf3;  6'd29: k_t = 32'hd5a79147;
      6'd30: k_t = 32'h06ca6351;  6'd31: k_t = 32'h14292967;
      6'd32: k_t = 32'h27b70a85;  6'd33: k_t = 32'h2e1b2138;
      6'd34: k_t = 32'h4d2c6dfc;  6'd35: k_t = 32'h53380d13;
      6'd36: k_t = 32'h650a7354;  6'd37: k_t = 32'h766a0abb;
      6'd38: k_t = 32'h81c2c92e;  6'd39: k_t = 32'h92722c85;
      6'd40: k_t = 32'ha2bfe8a1;  6'd41: k_t = 32'ha81a664b;
      6'd42: k_t = 32'hc24b8b70;  6'd43: k_t = 32'hc76c51a3;
      6'd44: k_t = 32'hd192e819;  6'd45: k_t = 32'hd6990624;
      6'd46: k_t = 32'hf40e3585;  6'd47: k_t = 32'h106aa070;
      6'd48: k_t = 32'h19a4c116;  6'd49: k_t = 32'h1e376c08;
      6'd50: k_t = 32'h2748774c;  6'd51: k_t = 32'h34b0bcb5;
      6'd52: k_t = 32'h391c0cb3;  6'd53: k_t = 32'h4ed8aa4a;
      6'd54: k_t = 32'h5b9cca4f;  6'd55: k_t = 32'h682e6ff3;
      6'd56: k_t = 32'h748f82ee;  6'd57: k_t = 32'h78a5636f;
      6'd58: k_t = 32'h84c87814;  6'd59: k_t = 32'h8cc70208;
      6'd60: k_t = 32'h90befffa;  6'd61: k_t = 32'ha4506ceb;
      6'd62: k_t = 32'hbef9a3f7;  6'd63: k_t = 32'hc67178f2;
      default: k_t = '0;
    endcase
  end

  // Schedule word for the current round; {t,5'b0} is 32*t.
  always_comb begin
    w_t = w_vector[{t_q, 5'b00000} +: 32];
  end

  // Round function datapath. Rotations are written as concatenations.
  always_comb begin
    sum0 = {a_q[1:0], a_q[31:2]} ^ {a_q[12:0], a_q[31:13]} ^ {a_q[21:0], a_q[31:22]};
    sum1 = {e_q[5:0], e_q[31:6]} ^ {e_q[10:0], e_q[31:11]} ^ {e_q[24:0], e_q[31:25]};
    ch   = (e_q & f_q) ^ (~e_q & g_q);
    maj  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t1   = h_q + sum1 + ch + k_t + w_t;
    t2   = sum0 + maj;
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    d_d          = d_q;
    e_d          = e_q;
    f_d          = f_q;
    g_d          = g_q;
    h_d          = h_q;
    hv_d         = hv_q;
    hash_out_d   = hash_out_q;
    hash_valid_d = 1'b0;

    if (abort) begin
      // Abort outranks every transition, including a start seen in idle.
      state_d = ST_IDLE;
      t_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            hv_d    = hash_in;
            a_d     = hash_in[255:224];
            b_d     = hash_in[223:192];
            c_d     = hash_in[191:160];
            d_d     = hash_in[159:128];
            e_d     = hash_in[127:96];
            f_d     = hash_in[95:64];
            g_d     = hash_in[63:32];
            h_d     = hash_in[31:0];
            t_d     = '0;
            state_d = ST_WAIT_W;
          end
        end
        ST_WAIT_W: begin
          if (w_vector_complete) begin
            t_d     = '0;
            state_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          h_d = g_q;
          g_d = f_q;
          f_d = e_q;
          e_d = d_q + t1;
          d_d = c_q;
          c_d = b_q;
          b_d = a_q;
          a_d = t1 + t2;
          t_d = t_q + 6'd1;
          if (t_q == 6'd63) begin
            state_d = ST_FINAL;
          end
        end
        ST_FINAL: begin
          hash_out_d   = {hv_q[255:224] + a_q, hv_q[223:192] + b_q,
                          hv_q[191:160] + c_q, hv_q[159:128] + d_q,
                          hv_q[127:96]  + e_q, hv_q[95:64]   + f_q,
                          hv_q[63:32]   + g_q, hv_q[31:0]    + h_q};
          hash_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      t_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      e_q          <= '0;
      f_q          <= '0;
      g_q          <= '0;
      h_q          <= '0;
      hv_q         <= '0;
      hash_out_q   <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      e_q          <= e_d;
      f_q          <= f_d;
      g_q          <= g_d;
      h_q          <= h_d;
      hv_q         <= hv_d;
      hash_out_q   <= hash_out_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    hash_valid = hash_valid_q;
    hash_out   = hash_out_q;
    case (state_q)
      ST_ROUND: round_index = {1'b0, t_q};
      ST_FINAL: round_index = 7'd63;
      default:  round_index = '0;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: a transaction-level golden
// model (schedule expansion + compression in plain loops) plus an abstract
// cycle tracker, compared against the DUT outputs every cycle, and directed
// vectors with literal digests.
module tb_sha256_round_engine;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic          w_vector_complete;
  logic [2047:0] w_vector;
  logic [255:0]  hash_in;
  logic          busy;
  logic          hash_valid;
  logic [255:0]  hash_out;
  logic [6:0]    round_index;

  sha256_round_engine #(.W_LENGTH(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .w_vector_complete (w_vector_complete),
    .w_vector          (w_vector),
    .hash_in           (hash_in),
    .busy              (busy),
    .hash_valid        (hash_valid),
    .hash_out          (hash_out),
    .round_index       (round_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] R0    = 256'h5d6aebcd6a09e667bb67ae853c6ef372fa2a4622510e527f9b05688c1f83d9ab;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Golden message schedule expander: 512-bit block, word 0 at the top.
  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) r[32*t +: 32] = w[t];
    return r;
  endfunction

  // Golden compression: nrounds rounds; with add=1 returns the new chaining
  // value, otherwise the raw working variables a..h.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] w,
                                            input int nrounds, input bit add);
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < nrounds; t++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[32*t +: 32];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++)
      r[255 - 32*i -: 32] = add ? hin[255 - 32*i -: 32] + v[i] : v[i];
    return r;
  endfunction

  // Abstract cycle tracker: busy flag, waiting flag, rounds completed
  // (64 means the add-back cycle); digest produced by the golden model.
  bit           m_busy, m_wait, m_valid;
  int           m_cnt;
  logic [255:0] m_hin, m_hout;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_wait <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
      m_hin <= '0; m_hout <= '0;
    end else if (abort) begin
      m_busy <= 1'b0; m_wait <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_wait <= 1'b1; m_cnt <= 0; m_hin <= hash_in;
        end
      end else if (m_wait) begin
        if (w_vector_complete) begin
          m_wait <= 1'b0; m_cnt <= 0;
        end
      end else if (m_cnt < 64) begin
        m_cnt <= m_cnt + 1;
      end else begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_hout  <= compress(m_hin, w_vector, 64, 1'b1);
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      int exp_ri;
      exp_ri = (m_busy && !m_wait) ? ((m_cnt < 64) ? m_cnt : 63) : 0;
      chk("cyc_busy", {255'd0, busy}, {255'd0, m_busy});
      chk("cyc_hash_valid", {255'd0, hash_valid}, {255'd0, m_valid});
      chk("cyc_hash_out", hash_out, m_hout);
      chk("cyc_round_index", {249'd0, round_index}, 256'(exp_ri));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one block; returns latency (edges after the start edge until
  // hash_valid is seen), number of valid pulses and cycles with busy low
  // before completion.
  task automatic run(input logic [255:0] hin, input logic [2047:0] w, input int delay_w,
                     input int poke_k, input bit chk_r0,
                     output int lat, output int pulses, output int gaps);
    hash_in = hin; w_vector = w; w_vector_complete = (delay_w == 0); start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    lat = -1; pulses = 0; gaps = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock); #1;
      if (hash_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && !busy) gaps++;
      if (chk_r0 && k == 2)
        chk("round0_vars", {dut.a_q, dut.b_q, dut.c_q, dut.d_q,
                            dut.e_q, dut.f_q, dut.g_q, dut.h_q}, R0);
      #1;
      if (k == delay_w) w_vector_complete = 1'b1;
      start = (k == poke_k);
      if (lat >= 0 && k >= lat + 3) break;
    end
    start = 1'b0;
    w_vector_complete = 1'b0;
  endtask

  logic [2047:0] w_abc, w_empty;
  logic [255:0]  prev, exp2;
  int            lat, pulses, gaps, lat2, seen;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; w_vector_complete = 1'b0;
    w_vector = '0; hash_in = '0;
    w_abc   = expand({32'h61626380, {14{32'h0}}, 32'h00000018});
    w_empty = expand({32'h80000000, {15{32'h0}}});

    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1'b1;
    chk("reset_busy", {255'd0, busy}, '0);
    chk("reset_valid", {255'd0, hash_valid}, '0);
    chk("reset_hash_out", hash_out, '0);
    chk("reset_round_index", {249'd0, round_index}, '0);
    #1 reset = 1'b1;

    chk("model_abc", compress(IV, w_abc, 64, 1'b1), ABC);
    chk("model_round0", compress(IV, w_abc, 1, 1'b0), R0);
    chk("model_empty", compress(IV, w_empty, 64, 1'b1), EMPTY);
    chk("model_k63", {224'd0, KT[63]}, {224'd0, w_abc[2047:2016] - w_abc[2047:2016] + 32'hc67178f2});

    // "abc" with a stray start during ROUND
    run(IV, w_abc, 0, 30, 1'b1, lat, pulses, gaps);
    chk("abc_latency", 256'(lat), 256'd66);
    chk("abc_pulses", 256'(pulses), 256'd1);
    chk("abc_busy_gaps", 256'(gaps), 256'd0);
    chk("abc_digest", hash_out, ABC);

    // empty message, W arriving 10 cycles late
    run(IV, w_empty, 10, 0, 1'b0, lat, pulses, gaps);
    chk("empty_latency", 256'(lat), 256'd76);
    chk("empty_pulses", 256'(pulses), 256'd1);
    chk("empty_busy_gaps", 256'(gaps), 256'd0);
    chk("empty_digest", hash_out, EMPTY);

    // back-to-back: second start issued while hash_valid is high
    exp2 = compress(ABC, w_empty, 64, 1'b1);
    hash_in = IV; w_vector = w_abc; w_vector_complete = 1'b1; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    lat = -1; lat2 = -1; seen = 0;
    for (int k = 1; k <= 250; k++) begin
      @(posedge clock); #1;
      if (hash_valid) begin
        seen++;
        if (lat < 0) begin
          lat = k;
          chk("b2b_first_digest", hash_out, ABC);
        end else if (lat2 < 0) begin
          lat2 = k;
          chk("b2b_second_digest", hash_out, exp2);
        end
      end
      #1;
      start = (lat == k);
      if (lat == k) begin
        hash_in = ABC; w_vector = w_empty;
      end
      if (lat2 >= 0 && k >= lat2 + 3) break;
    end
    start = 1'b0; w_vector_complete = 1'b0;
    chk("b2b_first_latency", 256'(lat), 256'd66);
    chk("b2b_second_latency", 256'(lat2), 256'd133);
    chk("b2b_pulses", 256'(seen), 256'd2);

    // abort at round 30
    prev = hash_out;
    hash_in = IV; w_vector = w_abc; w_vector_complete = 1'b1; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    seen = 0; lat = -1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clock); #1;
      if (hash_valid) seen++;
      #1;
      abort = (lat < 0 && round_index == 7'd30);
      if (abort) lat = k;
    end
    abort = 1'b0; w_vector_complete = 1'b0;
    chk("abort_reached_r30", 256'(lat > 0), 256'd1);
    chk("abort_no_valid", 256'(seen), 256'd0);
    chk("abort_busy", {255'd0, busy}, '0);
    chk("abort_hash_kept", hash_out, prev);

    // reset at round 30
    hash_in = IV; w_vector = w_abc; w_vector_complete = 1'b1; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clock); #1;
      if (round_index == 7'd30) lat = k;
      #1;
    end
    chk("rst_reached_r30", 256'(lat > 0), 256'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_busy", {255'd0, busy}, '0);
    chk("rst_valid", {255'd0, hash_valid}, '0);
    chk("rst_hash_out", hash_out, '0);
    chk("rst_round_index", {249'd0, round_index}, '0);
    #1 reset = 1'b1; w_vector_complete = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (hash_valid) seen++;
    end
    chk("rst_no_valid", 256'(seen), 256'd0);
    #1;

    // wrap-around: chaining value all ones
    run({8{32'hffffffff}}, w_abc, 0, 0, 1'b0, lat, pulses, gaps);
    chk("wrap_latency", 256'(lat), 256'd66);
    chk("wrap_digest", hash_out, compress({8{32'hffffffff}}, w_abc, 64, 1'b1));
    chk("wrap_ff_plus_vars", hash_out,
        compress({8{32'hffffffff}}, w_abc, 64, 1'b0) - {8{32'h00000001}});

    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

●

// File: doc/sha256_round_engine.md
# sha256_round_engine

Consumer of the expanded message schedule: waits for the 64-word `w_vector` from the schedule expander, runs the 64 SHA-256 compression rounds one per clock, and adds the working variables back into the chaining value. Sits between the W expander and the multi-block message controller, which supplies the incoming hash and collects `hash_out`.

## Interface
- `W_LENGTH`, 64: number of schedule words and rounds; only 64 is supported.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request to compress one block; sampled only in IDLE.
- `abort` in 1: synchronous; returns the engine to IDLE from any state.
- `w_vector_complete` in 1: the expander's `w_vector` is fully formed.
- `w_vector` in W_LENGTH*32: word t at bits [32t+31:32t].
- `hash_in` in 256: chaining value H0..H7; H0 is at [255:224], H7 at [31:0].
- `busy` out 1: high in WAIT_W, ROUND and FINAL.
- `hash_valid` out 1: one-cycle pulse when `hash_out` updates.
- `hash_out` out 256: new chaining value, same word order as `hash_in`.
- `round_index` out 7: current round t, 0..63.

## Operation
- **IDLE**
  - `start`=1 loads a..h and H0..H7 from `hash_in`, clears t, and moves to WAIT_W.
  - `start` in any other state is ignored.
- **WAIT_W**
  - When `w_vector_complete`=1, move to ROUND with t=0.
  - Otherwise hold indefinitely.
- **ROUND**, each clock:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - t←t+1. After the t=63 update, move to FINAL.
- **FINAL**
  - `hash_out`[word i] ← H_i + var_i, where var_i is a..h in order.
  - Pulse `hash_valid`, then go to IDLE.
- **Arithmetic**: all additions are mod 2^32; carries are discarded.
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22.
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25.
  - Ch = (e&f) ^ (~e&g).
  - Maj = (a&b) ^ (a&c) ^ (b&c).
- **K ROM**: the 64 FIPS 180-4 constants, indexed by t. K[0]=0x428a2f98, K[63]=0xc67178f2.
- **W[t]**: read combinationally from `w_vector`. Upstream holds `w_vector` stable from WAIT_W exit until `hash_valid`. `w_vector_complete` is ignored outside WAIT_W.
- **`abort`**: takes priority over every state transition. It clears `busy` and t and suppresses `hash_valid`. `hash_out` keeps its previous value.
- **Simultaneous `start` and `abort` in IDLE**: stay in IDLE.
- **`hash_out`**: holds its value until the next FINAL.

## Timing
- **Reset values**: `busy`=0, `hash_valid`=0, `hash_out`=0, `round_index`=0, state=IDLE, a..h=0, H=0.
- **Reset mid-operation**: immediate IDLE; no `hash_valid`.
- **Latency**, with `w_vector_complete` already high when `start` is sampled at edge N:
  - WAIT_W at N.
  - ROUND t=0 at N+1.
  - Rounds execute on edges N+2..N+65.
  - FINAL at N+65.
  - `hash_valid`=1 and `hash_out` valid after edge N+66; `busy` falls on the same edge.
- **General latency**: 66 cycles plus the number of cycles spent waiting in WAIT_W.
- **Back-to-back**: a `start` in the cycle `hash_valid` is high is accepted. The minimum issue interval is 67 cycles.
- **`round_index`**: equals t in ROUND, 63 in FINAL, and 0 otherwise.

## Test plan
- **"abc" block**: `hash_in`=IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, W from the golden expander, complete high -> 66 cycles later `hash_out`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with exactly one `hash_valid` pulse.
- **Round-0 trace ("abc")**: after the first ROUND edge -> a=5d6aebcd, b=6a09e667, c=bb67ae85, d=3c6ef372, e=fa2a4622, f=510e527f, g=9b05688c, h=1f83d9ab.
- **Empty message with delayed W**: `w_vector_complete` raised 10 cycles after `start` -> `busy` high throughout; `hash_out`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at 76 cycles.
- **Reset and abort mid-run**: `reset` low at round 30 -> all outputs read 0 on the next edge; separately, `abort` at round 30 -> IDLE, no `hash_valid`, previous `hash_out` retained.
- **Ignored start**: `start` pulsed during ROUND -> no effect on the result; a `start` issued the cycle `hash_valid` is high -> second block completes 66 cycles later with the correct digest.
- **Wrap-around**: `hash_in` all 0xffffffff with any valid W -> each output word equals (0xffffffff + var_i) mod 2^32, checked against the golden model.
